// File: rtl/keypad_scan_4x4.sv
// 4x4 hex keypad scanner: drives one column at a time, samples the rows at the end of each dwell,
// debounces whole 16-key frames and reports each newly pressed key as a one-cycle event.
module keypad_scan_4x4 #(
    parameter logic [15:0] SCAN_DIV       = 16'h7FFF,
    parameter int unsigned DEBOUNCE_SCANS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  ROW_N,
    input  logic        CLR,
    output logic [3:0]  COL_N,
    output logic [3:0]  KEY_CODE,
    output logic        KEY_VALID,
    output logic        KEY_DOWN,
    output logic [15:0] ENTRY
);

    localparam logic [3:0] DEB    = 4'(DEBOUNCE_SCANS);
    localparam logic [3:0] DEB_M1 = 4'(DEBOUNCE_SCANS - 1);

    logic [3:0]  r_row_s1;
    logic [3:0]  r_row_s2;
    logic [15:0] r_dwell;
    logic [1:0]  r_col;
    logic [3:0]  r_col_n;
    logic [11:0] r_snap;
    logic [15:0] r_last;
    logic [15:0] r_deb;
    logic [3:0]  r_match;
    logic [3:0]  r_code;
    logic        r_valid;
    logic        r_down;
    logic [15:0] r_entry;

    logic [3:0]  w_pressed;
    logic        w_sample;
    logic        w_frame_end;
    logic [15:0] w_frame;
    logic        w_same;
    logic        w_commit;
    logic [15:0] w_rise;
    logic        w_event;
    logic [1:0]  w_col_nx;
    logic [3:0]  w_code;

    assign w_pressed   = ~r_row_s2;
    assign w_sample    = (r_dwell == SCAN_DIV);
    assign w_frame_end = w_sample && (r_col == 2'd3);
    // The column-3 rows are taken live so the frame is complete on the frame-end edge.
    assign w_frame     = {w_pressed, r_snap};
    assign w_same      = (w_frame == r_last);
    assign w_commit    = w_frame_end && w_same && (r_match >= DEB_M1);
    assign w_rise      = w_frame & ~r_deb;
    assign w_event     = w_commit && (|w_rise);
    assign w_col_nx    = r_col + 2'd1;

    always_comb begin
        w_code = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (w_rise[i]) w_code = 4'(i);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_row_s1 <= 4'hF;
            r_row_s2 <= 4'hF;
        end else begin
            r_row_s1 <= ROW_N;
            r_row_s2 <= r_row_s1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_dwell <= 16'd0;
            r_col   <= 2'd0;
            r_col_n <= 4'b1110;
            r_snap  <= 12'd0;
        end else if (w_sample) begin
            r_dwell <= 16'd0;
            r_col   <= w_col_nx;
            r_col_n <= ~(4'b0001 << w_col_nx);
            case (r_col)
                2'd0:    r_snap[3:0]  <= w_pressed;
                2'd1:    r_snap[7:4]  <= w_pressed;
                2'd2:    r_snap[11:8] <= w_pressed;
                default: ;
            endcase
        end else begin
            r_dwell <= r_dwell + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_last  <= 16'd0;
            r_match <= 4'd0;
        end else if (w_frame_end) begin
            r_last <= w_frame;
            if (!w_same)           r_match <= 4'd0;
            else if (r_match >= DEB) r_match <= DEB;
            else                   r_match <= r_match + 4'd1;
        end
    end

    // KEY_VALID is a one-cycle strobe with no back-pressure; KEY_CODE is valid while it is high and holds after.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_deb   <= 16'd0;
            r_down  <= 1'b0;
            r_code  <= 4'd0;
            r_valid <= 1'b0;
            r_entry <= 16'd0;
        end else begin
            r_valid <= w_event;
            if (w_commit) begin
                r_deb  <= w_frame;
                r_down <= |w_frame;
            end
            if (w_event) r_code <= w_code;
            if (CLR)          r_entry <= 16'd0;
            else if (w_event) r_entry <= {r_entry[11:0], w_code};
        end
    end

    assign COL_N     = r_col_n;
    assign KEY_CODE  = r_code;
    assign KEY_VALID = r_valid;
    assign KEY_DOWN  = r_down;
    assign ENTRY     = r_entry;

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Bench for keypad_scan_4x4: a simulated key matrix answers the column drive, a frame-history model
// predicts every output each cycle, and literal checkpoints pin the expected key sequence.
module tb_keypad_scan_4x4;

    localparam int DIV = 3;
    localparam int DEB = 2;
    localparam int FR  = 4 * (DIV + 1);

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        CLR = 1'b0;
    logic [3:0]  ROW_N;
    logic [3:0]  COL_N;
    logic [3:0]  KEY_CODE;
    logic        KEY_VALID;
    logic        KEY_DOWN;
    logic [15:0] ENTRY;
    logic [15:0] keys = 16'd0;

    keypad_scan_4x4 #(.SCAN_DIV(16'(DIV)), .DEBOUNCE_SCANS(DEB)) dut (
        .CLK(CLK), .RST(RST), .ROW_N(ROW_N), .CLR(CLR), .COL_N(COL_N),
        .KEY_CODE(KEY_CODE), .KEY_VALID(KEY_VALID), .KEY_DOWN(KEY_DOWN), .ENTRY(ENTRY)
    );

    always #5 CLK = ~CLK;

    // A pressed key pulls its row low while its column is driven.
    always_comb begin
        ROW_N = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!COL_N[c] && keys[c*4+r]) ROW_N[r] = 1'b0;
    end

    int n_vec = 0;
    int n_err = 0;
    int tb_cyc = 0;
    int n_pulses = 0;
    int last_pulse_cyc = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Model state: cycle count since reset, 2-deep synchronizer pipe, frame history.
    int          m_cyc;
    logic [3:0]  m_p1, m_p2;
    logic [15:0] m_acc;
    logic [15:0] m_hist[$];
    logic [15:0] m_deb, m_entry;
    logic [3:0]  m_code;
    logic        m_valid, m_down;
    logic [3:0]  cap_row = 4'hF;
    logic        cap_clr = 1'b0;
    logic        cap_rst = 1'b0;

    task automatic model_reset();
        m_cyc = 0; m_p1 = 4'd0; m_p2 = 4'd0; m_acc = 16'd0;
        m_hist.delete(); m_hist.push_back(16'd0);
        m_deb = 16'd0; m_entry = 16'd0; m_code = 4'd0; m_valid = 1'b0; m_down = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0]  pr;
        logic [15:0] rise;
        int          c;
        bit          same;
        pr = m_p2; m_p2 = m_p1; m_p1 = ~cap_row;
        m_valid = 1'b0;
        if (m_cyc % 4 == 3) begin
            c = (m_cyc / 4) % 4;
            m_acc[c*4 +: 4] = pr;
            if (c == 3) begin
                m_hist.push_back(m_acc);
                if (m_hist.size() > DEB + 1) void'(m_hist.pop_front());
                same = (m_hist.size() == DEB + 1);
                foreach (m_hist[i]) if (m_hist[i] != m_acc) same = 1'b0;
                if (same) begin
                    rise  = m_acc & ~m_deb;
                    m_deb  = m_acc;
                    m_down = |m_acc;
                    for (int i = 0; i < 16; i++) begin
                        if (rise[i]) begin
                            m_code  = 4'(i);
                            m_valid = 1'b1;
                            m_entry = {m_entry[11:0], m_code};
                            break;
                        end
                    end
                end
            end
        end
        if (cap_clr) m_entry = 16'd0;
        m_cyc++;
    endtask

    always @(posedge CLK) begin
        cap_row = ROW_N;
        cap_clr = CLR;
        cap_rst = RST;
        tb_cyc++;
    end

    always @(negedge CLK) begin
        logic [3:0] exp_coln;
        logic [3:0] e;
        if (!RST) model_reset();
        else if (cap_rst) model_step();
        exp_coln = ~(4'b0001 << ((m_cyc / 4) % 4));
        check("col_n", 32'(COL_N), 32'(exp_coln));
        check("key_valid", 32'(KEY_VALID), 32'(m_valid));
        check("key_code", 32'(KEY_CODE), 32'(m_code));
        check("key_down", 32'(KEY_DOWN), 32'(m_down));
        check("entry", 32'(ENTRY), 32'(m_entry));
        if (KEY_VALID === 1'b1) begin
            n_pulses++;
            last_pulse_cyc = tb_cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'(KEY_CODE), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("event_code", 32'(KEY_CODE), 32'(e));
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic press_release(input int idx);
        exp_q.push_back(4'(idx));
        keys[idx] = 1'b1;
        wait_cyc(6 * FR);
        keys[idx] = 1'b0;
        wait_cyc(6 * FR);
    endtask

    int press_cyc;
    int lat;

    initial begin
        // Test 1: reset then idle.
        wait_cyc(3);
        @(negedge CLK); #1 RST = 1'b1;
        check("col_after_reset", 32'(COL_N), 32'h0000_000E);
        wait_cyc(200);
        check("idle_entry", 32'(ENTRY), 32'h0);
        check("idle_pulses", 32'(n_pulses), 32'd0);

        // Test 2: single key A, held then released.
        exp_q.push_back(4'hA);
        press_cyc = tb_cyc;
        keys[10] = 1'b1;
        wait_cyc(6 * FR);
        lat = last_pulse_cyc - press_cyc;
        check("a_entry", 32'(ENTRY), 32'h0000_000A);
        check("a_code", 32'(KEY_CODE), 32'hA);
        check("a_down", 32'(KEY_DOWN), 32'd1);
        check("a_pulses", 32'(n_pulses), 32'd1);
        check("a_latency_in_range", 32'(lat >= 2 * FR && lat <= (DEB + 2) * FR + 2), 32'd1);
        keys[10] = 1'b0;
        wait_cyc(6 * FR);
        check("a_release_down", 32'(KEY_DOWN), 32'd0);
        check("a_release_pulses", 32'(n_pulses), 32'd1);

        // Test 3: sequence 1,2,3,4 then F.
        for (int k = 1; k <= 4; k++) press_release(k);
        check("seq_entry", 32'(ENTRY), 32'h0000_1234);
        check("seq_model_entry", 32'(m_entry), 32'h0000_1234);
        press_release(15);
        check("seq_f_entry", 32'(ENTRY), 32'h0000_234F);
        check("seq_pulses", 32'(n_pulses), 32'd6);

        // Test 4: key 5 bounces frame by frame, then settles pressed.
        exp_q.push_back(4'h5);
        for (int k = 0; k < 5; k++) begin
            keys[5] = ~keys[5];
            wait_cyc(FR);
        end
        check("bounce_no_event", 32'(n_pulses), 32'd6);
        wait_cyc(6 * FR);
        check("bounce_pulses", 32'(n_pulses), 32'd7);
        check("bounce_entry", 32'(ENTRY), 32'h0000_34F5);
        keys[5] = 1'b0;
        wait_cyc(6 * FR);

        // Test 5: keys 3 and C pressed together; only 3 is reported.
        exp_q.push_back(4'h3);
        keys[3] = 1'b1; keys[12] = 1'b1;
        wait_cyc(6 * FR);
        check("dual_pulses", 32'(n_pulses), 32'd8);
        check("dual_code", 32'(KEY_CODE), 32'h3);
        check("dual_entry", 32'(ENTRY), 32'h0000_4F53);
        keys[3] = 1'b0;
        wait_cyc(6 * FR);
        check("dual_release3_pulses", 32'(n_pulses), 32'd8);
        check("dual_c_still_down", 32'(KEY_DOWN), 32'd1);
        keys[12] = 1'b0;
        wait_cyc(6 * FR);
        check("dual_all_up", 32'(KEY_DOWN), 32'd0);

        // Test 6a: CLR held across the event edge.
        CLR = 1'b1;
        exp_q.push_back(4'h7);
        keys[7] = 1'b1;
        wait_cyc(6 * FR);
        check("clr_entry", 32'(ENTRY), 32'h0);
        check("clr_code", 32'(KEY_CODE), 32'h7);
        check("clr_pulses", 32'(n_pulses), 32'd9);
        CLR = 1'b0;
        keys[7] = 1'b0;
        wait_cyc(6 * FR);

        // Test 6b: reset pulsed mid-frame with key 6 held.
        exp_q.push_back(4'h6);
        keys[6] = 1'b1;
        wait_cyc(6 * FR);
        check("pre_rst_entry", 32'(ENTRY), 32'h0000_0006);
        wait_cyc(5);
        RST = 1'b0;
        wait_cyc(2);
        check("rst_col_n", 32'(COL_N), 32'h0000_000E);
        check("rst_code", 32'(KEY_CODE), 32'h0);
        check("rst_down", 32'(KEY_DOWN), 32'd0);
        check("rst_entry", 32'(ENTRY), 32'h0);
        check("rst_valid", 32'(KEY_VALID), 32'd0);
        @(negedge CLK); #1 RST = 1'b1;
        exp_q.push_back(4'h6);
        wait_cyc(6 * FR);
        check("post_rst_entry", 32'(ENTRY), 32'h0000_0006);
        check("post_rst_down", 32'(KEY_DOWN), 32'd1);
        check("post_rst_pulses", 32'(n_pulses), 32'd11);
        keys[6] = 1'b0;
        wait_cyc(6 * FR);

        check("events_outstanding", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_scan_4x4.md
Name: keypad_scan_4x4

Overview:
- Input-side counterpart to the multiplexed 7-segment driver: it drives the columns of a 4x4 hex keypad one at a time and reads the rows back.
- Per scan: synchronize the row inputs, debounce whole scan frames, emit a one-cycle event with the hex code of each newly pressed key.
- Keeps the last four key codes as a 16-bit entry word that connects directly to a display data input.
- Sits at top level between the board keypad pins and the display/user logic.

Parameters:
SCAN_DIV, 16'h7FFF, dwell cycles per column minus 1 (one column is held for SCAN_DIV+1 cycles)
DEBOUNCE_SCANS, 2, consecutive identical frames (after the first) required before a frame is accepted; legal range 1..15

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous, active-low reset
ROW_N  input  4  keypad rows, active-low (pulled up), asynchronous to CLK
CLR  input  1  synchronous clear of ENTRY, active-high
COL_N  output  4  column drive, active-low one-hot
KEY_CODE  output  4  code of last reported key = {col[1:0], row[1:0]}
KEY_VALID  output  1  one-cycle pulse, new key press reported
KEY_DOWN  output  1  level, at least one key is set in the debounced state
ENTRY  output  16  last four codes, newest in [3:0]

Behaviour:
- Reset (RST low, asynchronous), all outputs:
  - COL_N=4'b1110, KEY_CODE=0, KEY_VALID=0, KEY_DOWN=0, ENTRY=0.
  - Internal state: col=0, dwell=0, snapshot/last/debounced=0, match_cnt=0, synchronizers to 4'hF.
- Row synchronizer:
  - Two flip-flops on ROW_N; pressed = ~sync.
- Scan:
  - 16-bit dwell counter counts 0..SCAN_DIV.
  - At dwell==SCAN_DIV:
    - Store pressed[3:0] into frame bits [col*4+3 : col*4].
    - dwell<=0; col<=col+1, wrapping 3->0.
    - COL_N<=~(1<<new col).
  - Sampling at the end of the dwell gives the lines time to settle.
- Frame end is the sample edge with col==3. The frame value includes the column-3 sample taken on that edge.
- At frame end, match logic:
  - If frame==last: match_cnt<=min(match_cnt+1, DEBOUNCE_SCANS). Otherwise match_cnt<=0.
  - last<=frame.
  - Commit condition: frame==last AND match_cnt>=DEBOUNCE_SCANS-1. A held pattern therefore commits at the end of its (DEBOUNCE_SCANS+1)-th consecutive identical frame.
- On commit:
  - rise = frame & ~debounced; debounced<=frame.
  - If rise!=0, on the same edge:
    - KEY_CODE <= index of the lowest set bit of rise.
    - KEY_VALID<=1 for exactly one cycle.
    - ENTRY<={ENTRY[11:0], code}.
  - If rise==0: no event, and KEY_CODE holds its value.
- KEY_DOWN is registered, =|debounced, and updates on the commit edge.
- Releases generate no event. They only clear bits in debounced.
- Multiple new presses committing together: only the lowest index is reported. The others are absorbed into debounced and never reported.
- A bounce that breaks a run of identical frames resets match_cnt, so the count restarts.
- CLR:
  - CLR=1 forces ENTRY<=0 on that edge and takes priority over a shift.
  - A coincident key event still pulses KEY_VALID and updates KEY_CODE.
- Reset mid-scan restores the reset values listed above. A key still held after reset is reported once it has been stable for DEBOUNCE_SCANS+1 full frames.
- Latency:
  - Frame = 4*(SCAN_DIV+1) cycles.
  - Press-to-KEY_VALID is at most (DEBOUNCE_SCANS+2) frames + 2 cycles (synchronizer).

Test Plan (SCAN_DIV=3, DEBOUNCE_SCANS=2, so frame=16 cycles):
1. Reset then idle 200 cycles.
   - COL_N steps 1110,1101,1011,0111, each held 4 cycles, repeating.
   - KEY_VALID never asserted; ENTRY=0.
2. Model key col2/row2 held: ROW_N[2]=0 whenever COL_N[2]=0.
   - Exactly one KEY_VALID pulse, KEY_CODE=4'hA, ENTRY=16'h000A, KEY_DOWN=1.
   - Pulse occurs at the end of the 3rd identical frame.
   - Release: KEY_DOWN falls after 3 frames with no KEY_VALID.
3. Press keys 1,2,3,4 in sequence (press 6 frames, release 6 frames each).
   - Four pulses with codes 1,2,3,4; ENTRY=16'h1234.
   - Fifth key F gives ENTRY=16'h234F.
4. Bouncing key 5 (col1/row1): toggles every frame for 5 frames, then held.
   - No event while bouncing; one event, code 5, after 3 stable frames.
5. Keys 3 and C newly pressed in the same frame.
   - One pulse with KEY_CODE=3.
   - Releasing 3 while C stays held gives no new event.
6. Edge cases:
   - CLR asserted on the KEY_VALID cycle: ENTRY=0 while KEY_CODE updates.
   - RST pulsed mid-frame with a key held: outputs return to reset values, then the key is reported again after 3 frames.
